// File: rtl/zled_pkg.sv
// Shared types and constants for the status-LED blink-code scheduler.
// No logic; no latency or flow control of its own.
package zled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } zled_state_t;

  localparam int CODE_W           = 4;
  localparam int DEF_TICK_DIV     = 2_500_000;
  localparam int DEF_ON_TICKS     = 2;
  localparam int DEF_OFF_TICKS    = 2;
  localparam int DEF_GAP_TICKS    = 8;
  localparam int HB_PERIOD        = 10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/zled_tick_gen.sv
// Prescaler: 1-cycle tick every TICK_DIV cycles, synchronous clear restarts the count.
// Tick is decoded from the counter register; no backpressure.
module zled_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/zled_pattern_ctrl.sv
// Fixed-priority LED sharer: winner blinks its code (N pulses + gap), outputs registered, grant visible 1 cycle after eligibility.
// Non-preemptive; dropping the request aborts to the gap. ZLED_HEARTBEAT_EN adds an idle heartbeat on oLed.
module zled_pattern_ctrl
  import zled_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  input  logic [NUM_SRC-1:0]         iReq,
  input  logic [CODE_W*NUM_SRC-1:0]  iCode,
  output logic                       oLed,
  output logic [NUM_SRC-1:0]         oGrant,
  output logic                       oBusy
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PH_W  = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);

  zled_state_t         state, state_nxt;
  logic [PH_W-1:0]     phase, phase_nxt;
  logic [CODE_W-1:0]   pulse, pulse_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt, sel;
  logic                any_elig, tick, clr;
  logic                led_nxt, busy_nxt;
  logic [NUM_SRC-1:0]  grant_nxt;

  zled_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (iClk),
    .rst_n (iRstN),
    .clr   (clr),
    .tick  (tick)
  );

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (iReq[k] && (iCode[CODE_W*k +: CODE_W] != '0)) begin
        any_elig = 1'b1;
        sel      = IDX_W'(k);
      end
    end
  end

`ifdef ZLED_HEARTBEAT_EN
  logic [3:0] hb_cnt, hb_nxt;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) hb_cnt <= '0;
    else        hb_cnt <= hb_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    pulse_nxt = pulse;
    idx_nxt   = idx;
    clr       = 1'b0;
    led_nxt   = 1'b0;
    grant_nxt = oGrant;
    busy_nxt  = oBusy;
`ifdef ZLED_HEARTBEAT_EN
    hb_nxt    = hb_cnt;
`endif
    case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (any_elig) begin
          state_nxt      = ST_ON;
          idx_nxt        = sel;
          pulse_nxt      = iCode[CODE_W*int'(sel) +: CODE_W];
          phase_nxt      = '0;
          clr            = 1'b1;
          led_nxt        = 1'b1;
          grant_nxt[sel] = 1'b1;
          busy_nxt       = 1'b1;
        end
`ifdef ZLED_HEARTBEAT_EN
        else begin
          if (tick) hb_nxt = (hb_cnt == 4'(HB_PERIOD - 1)) ? '0 : hb_cnt + 1'b1;
          led_nxt = (hb_nxt == 4'(HB_PERIOD - 1));
        end
`endif
      end
      ST_ON, ST_OFF: begin
        led_nxt = (state == ST_ON);
        if (!iReq[idx]) begin
          // Abort restarts the prescaler too, so the gap is full length.
          state_nxt = ST_GAP;
          phase_nxt = '0;
          clr       = 1'b1;
          led_nxt   = 1'b0;
        end else if (tick) begin
          if (state == ST_ON && phase == PH_W'(ON_TICKS - 1)) begin
            phase_nxt = '0;
            pulse_nxt = pulse - 1'b1;
            led_nxt   = 1'b0;
            state_nxt = (pulse == CODE_W'(1)) ? ST_GAP : ST_OFF;
          end else if (state == ST_OFF && phase == PH_W'(OFF_TICKS - 1)) begin
            phase_nxt = '0;
            led_nxt   = 1'b1;
            state_nxt = ST_ON;
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (phase == PH_W'(GAP_TICKS - 1)) begin
            phase_nxt = '0;
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= ST_IDLE;
      phase  <= '0;
      pulse  <= '0;
      idx    <= '0;
      oLed   <= 1'b0;
      oGrant <= '0;
      oBusy  <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      pulse  <= pulse_nxt;
      idx    <= idx_nxt;
      oLed   <= led_nxt;
      oGrant <= grant_nxt;
      oBusy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_zled_pattern_ctrl.sv
// Directed bench for zled_pattern_ctrl with TICK_DIV=4, ON=2, OFF=2, GAP=4 (one tick = 4 cycles).
module tb_zled_pattern_ctrl;

  logic        iClk;
  logic        iRstN;
  logic [3:0]  iReq;
  logic [15:0] iCode;
  logic        oLed;
  logic [3:0]  oGrant;
  logic        oBusy;

  int n_cmp;
  int n_bad;

  zled_pattern_ctrl #(
    .NUM_SRC   (4),
    .TICK_DIV  (4),
    .ON_TICKS  (2),
    .OFF_TICKS (2),
    .GAP_TICKS (4)
  ) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iReq   (iReq),
    .iCode  (iCode),
    .oLed   (oLed),
    .oGrant (oGrant),
    .oBusy  (oBusy)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] code;
    logic        led;
    logic [3:0]  grant;
    logic        busy;
    int          cycles;
    string       name;
  } seg_t;

  seg_t tbl[$];

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    iReq  = '0;
    iCode = '0;
    step();
    step();
    iRstN = 1'b1;
    step();
  endtask

  function automatic seg_t mk(input logic rst, input logic [3:0] req, input logic [15:0] code,
                              input logic led, input logic [3:0] grant, input logic busy,
                              input int cycles, input string name);
    seg_t s;
    s.rst = rst; s.req = req; s.code = code; s.led = led;
    s.grant = grant; s.busy = busy; s.cycles = cycles; s.name = name;
    return s;
  endfunction

  initial begin
    int hb_seen;
    int hb_len;
    n_cmp = 0;
    n_bad = 0;

    // Pulse timing: src1 code 3, then one IDLE cycle and immediate re-grant.
    tbl.push_back(mk(1, 4'b0010, 16'h0030, 1, 4'b0010, 1,  8, "p_on1"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 0, 4'b0010, 1,  8, "p_off1"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 1, 4'b0010, 1,  8, "p_on2"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 0, 4'b0010, 1,  8, "p_off2"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 1, 4'b0010, 1,  8, "p_on3"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 0, 4'b0010, 1, 16, "p_gap"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 0, 4'b0000, 0,  1, "p_idle"));
    tbl.push_back(mk(0, 4'b0010, 16'h0030, 1, 4'b0010, 1,  1, "p_regrant"));
    // Priority: src2 code 2 running, src0 raised mid-pulse waits for IDLE.
    tbl.push_back(mk(1, 4'b0100, 16'h0201, 1, 4'b0100, 1,  4, "pr_on1a"));
    tbl.push_back(mk(0, 4'b0101, 16'h0201, 1, 4'b0100, 1,  4, "pr_on1b"));
    tbl.push_back(mk(0, 4'b0101, 16'h0201, 0, 4'b0100, 1,  8, "pr_off1"));
    tbl.push_back(mk(0, 4'b0101, 16'h0201, 1, 4'b0100, 1,  8, "pr_on2"));
    tbl.push_back(mk(0, 4'b0101, 16'h0201, 0, 4'b0100, 1, 16, "pr_gap"));
    tbl.push_back(mk(0, 4'b0101, 16'h0201, 0, 4'b0000, 0,  1, "pr_idle"));
    tbl.push_back(mk(0, 4'b0101, 16'h0201, 1, 4'b0001, 1,  1, "pr_src0"));
    // Abort: src3 code 5 drops its request during the 2nd ON.
    tbl.push_back(mk(1, 4'b1000, 16'h5000, 1, 4'b1000, 1,  8, "ab_on1"));
    tbl.push_back(mk(0, 4'b1000, 16'h5000, 0, 4'b1000, 1,  8, "ab_off1"));
    tbl.push_back(mk(0, 4'b1000, 16'h5000, 1, 4'b1000, 1,  3, "ab_on2"));
    tbl.push_back(mk(0, 4'b0000, 16'h5000, 0, 4'b1000, 1, 16, "ab_gap"));
    tbl.push_back(mk(0, 4'b0000, 16'h5000, 0, 4'b0000, 0,  3, "ab_idle"));
    // Code 0 is ineligible; lower-priority eligible src2 wins instead.
    tbl.push_back(mk(1, 4'b0010, 16'h0000, 0, 4'b0000, 0, 20, "inel_none"));
    tbl.push_back(mk(0, 4'b0110, 16'h0300, 1, 4'b0100, 1,  2, "inel_skip"));

    // Reset values with all sources requesting, then first grant after release.
    iRstN = 1'b0;
    iReq  = 4'hF;
    iCode = 16'h1111;
    step();
    step();
    chk("rst_led",   oLed,   0);
    chk("rst_grant", oGrant, 0);
    chk("rst_busy",  oBusy,  0);
    iRstN = 1'b1;
    step();
    chk("first_grant", oGrant, 4'b0001);
    chk("first_led",   oLed,   1);
    chk("first_busy",  oBusy,  1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      for (int c = 0; c < tbl[i].cycles; c++) begin
        iReq  = tbl[i].req;
        iCode = tbl[i].code;
        step();
        chk({tbl[i].name, "_led"},   oLed,   tbl[i].led);
        chk({tbl[i].name, "_grant"}, oGrant, tbl[i].grant);
        chk({tbl[i].name, "_busy"},  oBusy,  tbl[i].busy);
      end
    end

    // Code changes mid-pattern are ignored: src0 code 1 stays a single pulse.
    do_reset();
    iReq  = 4'b0001;
    iCode = 16'h0001;
    step();
    iCode = 16'h000F;
    for (int c = 0; c < 8; c++) step();
    chk("code_hold_led",  oLed,   0);
    for (int c = 0; c < 15; c++) step();
    chk("code_hold_gap",  oGrant, 4'b0001);
    step();
    chk("code_hold_idle", oBusy,  0);

    // Async reset asserted mid-OFF clears outputs before the next edge.
    do_reset();
    iReq  = 4'b0001;
    iCode = 16'h0002;
    for (int c = 0; c < 11; c++) step();
    chk("mid_off_led",  oLed,  0);
    chk("mid_off_busy", oBusy, 1);
    #1 iRstN = 1'b0;
    #1;
    chk("async_grant", oGrant, 0);
    chk("async_busy",  oBusy,  0);
    chk("async_led",   oLed,   0);
    iReq = '0;
    step();
    iRstN = 1'b1;
    for (int c = 0; c < 5; c++) step();
    chk("no_resume_grant", oGrant, 0);

`ifdef ZLED_HEARTBEAT_EN
    // Heartbeat: 4 lit cycles every 40 while idle.
    do_reset();
    hb_seen = 0;
    for (int c = 0; c < 100 && !hb_seen; c++) begin
      step();
      if (oLed) hb_seen = 1;
    end
    chk("hb_seen", hb_seen, 1);
    hb_len = 1;
    for (int c = 0; c < 39; c++) begin
      step();
      if (oLed) hb_len++;
    end
    chk("hb_lit_len", hb_len, 4);
    step();
    chk("hb_period", oLed, 1);
    step();
    iReq  = 4'b0001;
    iCode = 16'h0001;
    step();
    chk("hb_override_grant", oGrant, 4'b0001);
    chk("hb_override_led",   oLed,   1);
`else
    do_reset();
    hb_len = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (oLed) hb_len++;
    end
    chk("idle_led_dark", hb_len, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
